// File: rtl/breakout_physics.sv
// Per-frame Breakout engine: on each accepted frame_tick it scans the 12 bricks
// one per cycle, then commits wall/paddle/miss resolution and the new ball position.
module breakout_physics #(
  parameter int START_ROW  = 420,
  parameter int START_COL  = 400,
  parameter int LIVES      = 3,
  parameter int PADDLE_W   = 64,
  parameter int BRICK_LEFT = 40,
  parameter int BRICK_TOP  = 100,
  parameter int BRICK_W    = 90,
  parameter int BRICK_H    = 30,
  parameter int ROW_PITCH  = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start_pulse,
  input  logic [9:0]  paddle_left,
  output logic [8:0]  ball_row,
  output logic [9:0]  ball_col,
  output logic [11:0] brick_alive,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [2:0]  state,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, MISS = 3'd2, WON = 3'd3, OVER = 3'd4} game_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SCAN, PH_COMMIT} phase_t;

  game_t  game, game_next;
  phase_t phase, phase_next;
  logic [3:0]  idx, cidx;
  logic        hit, dir_up, dir_left;
  logic [10:0] row, col, pad, cand_row, cand_col, row_eff;
  logic [10:0] new_row, new_col, brick_top, brick_left;
  logic        overlap, up_eff, new_up, new_left, missed, restart;
  logic [1:0]  lives_dec;

  assign restart   = start_pulse && (game != PLAY);
  assign lives_dec = lives - 2'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      game  <= IDLE;
      phase <= PH_IDLE;
    end else begin
      game  <= game_next;
      phase <= phase_next;
    end
  end

  always_comb begin
    game_next  = game;
    phase_next = phase;
    if (restart) game_next = PLAY;
    case (phase)
      PH_IDLE: if (game == PLAY && frame_tick) phase_next = PH_SCAN;
      PH_SCAN: if (idx == 4'd11) phase_next = PH_COMMIT;
      PH_COMMIT: begin
        phase_next = PH_IDLE;
        if (missed) game_next = (lives_dec == 2'd0) ? OVER : MISS;
        if (brick_alive == 12'd0) game_next = WON;
      end
      default: phase_next = PH_IDLE;
    endcase
  end

  always_comb begin
    busy  = (phase != PH_IDLE);
    state = game;
  end

  // The vertical flip from a brick hit is held in 'hit' and folded in at commit.
  always_comb begin
    row      = {2'b00, ball_row};
    col      = {1'b0, ball_col};
    pad      = {1'b0, paddle_left};
    cand_row = dir_up ? row - 11'd2 : row + 11'd2;
    cand_col = dir_left ? col - 11'd1 : col + 11'd1;

    cidx       = (idx >= 4'd6) ? idx - 4'd6 : idx;
    brick_top  = (idx >= 4'd6) ? 11'(BRICK_TOP + ROW_PITCH) : 11'(BRICK_TOP);
    brick_left = 11'(BRICK_LEFT) + 11'(cidx) * 11'(BRICK_W);
    overlap    = (idx < 4'd12) && brick_alive[idx] &&
                 (cand_row + 11'd3 >= brick_top) &&
                 (cand_row <= brick_top + 11'(BRICK_H - 1)) &&
                 (cand_col + 11'd3 >= brick_left) &&
                 (cand_col <= brick_left + 11'(BRICK_W - 1));

    up_eff  = dir_up ^ hit;
    row_eff = hit ? row : cand_row;

    new_col  = cand_col;
    new_left = dir_left;
    if (dir_left && cand_col < 11'd40) begin
      new_col  = 11'd40;
      new_left = 1'b0;
    end else if (!dir_left && cand_col + 11'd3 > 11'd589) begin
      new_col  = 11'd586;
      new_left = 1'b1;
    end

    new_row = row_eff;
    new_up  = up_eff;
    missed  = 1'b0;
    if (up_eff && row_eff < 11'd30) begin
      new_row = 11'd30;
      new_up  = 1'b0;
    end else if (!up_eff && (row + 11'd3 < 11'd440) && (row_eff + 11'd3 >= 11'd440) &&
                 (new_col + 11'd3 >= pad) && (new_col <= pad + 11'(PADDLE_W - 1))) begin
      new_row = 11'd436;
      new_up  = 1'b1;
    end else if (row_eff > 11'd476) begin
      missed = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ball_row    <= 9'(START_ROW);
      ball_col    <= 10'(START_COL);
      brick_alive <= 12'hFFF;
      score       <= 8'd0;
      lives       <= 2'(LIVES);
      dir_up      <= 1'b1;
      dir_left    <= 1'b1;
      idx         <= 4'd0;
      hit         <= 1'b0;
    end else if (restart) begin
      ball_row <= 9'(START_ROW);
      ball_col <= 10'(START_COL);
      dir_up   <= 1'b1;
      dir_left <= 1'b1;
      if (game != MISS) begin
        brick_alive <= 12'hFFF;
        score       <= 8'd0;
        lives       <= 2'(LIVES);
      end
    end else begin
      case (phase)
        PH_IDLE: begin
          idx <= 4'd0;
          hit <= 1'b0;
        end
        PH_SCAN: begin
          if (!hit && overlap) begin
            brick_alive[idx] <= 1'b0;
            if (score != 8'hFF) score <= score + 8'd1;
            hit <= 1'b1;
          end
          idx <= idx + 4'd1;
        end
        PH_COMMIT: begin
          dir_up   <= new_up;
          dir_left <= new_left;
          if (missed) begin
            ball_row <= 9'(START_ROW);
            ball_col <= 10'(START_COL);
            lives    <= lives_dec;
          end else begin
            ball_row <= 9'(new_row);
            ball_col <= 10'(new_col);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_breakout_physics.sv
// Self-checking bench for breakout_physics: directed game scenarios followed by
// randomized ticks/starts/paddle positions against a frame-level game model.
module tb_breakout_physics;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start_pulse = 1'b0;
  logic [9:0]  paddle_left = 10'd40;
  logic [8:0]  ball_row;
  logic [9:0]  ball_col;
  logic [11:0] brick_alive;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic [2:0]  state;
  logic        busy;

  int total = 0;
  int bad = 0;

  int m_row, m_col, m_score, m_lives, m_state;
  bit m_up, m_left;
  logic [11:0] m_alive;

  breakout_physics dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .start_pulse(start_pulse),
    .paddle_left(paddle_left), .ball_row(ball_row), .ball_col(ball_col),
    .brick_alive(brick_alive), .score(score), .lives(lives), .state(state), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic modelReset();
    m_row = 420; m_col = 400; m_alive = 12'hFFF; m_score = 0; m_lives = 3;
    m_state = 0; m_up = 1; m_left = 1;
  endtask

  task automatic modelStart();
    if (m_state != 2) begin
      m_alive = 12'hFFF; m_score = 0; m_lives = 3;
    end
    m_row = 420; m_col = 400; m_up = 1; m_left = 1; m_state = 1;
  endtask

  // One frame of game physics in plain integer arithmetic.
  task automatic modelFrame(input int pad);
    int nr, nc;
    bit hit, missed;
    nr = m_up ? m_row - 2 : m_row + 2;
    nc = m_left ? m_col - 1 : m_col + 1;
    hit = 0;
    for (int i = 0; i < 12; i++) begin
      int top, left;
      top  = 100 + (i / 6) * 50;
      left = 40 + (i % 6) * 90;
      if (!hit && m_alive[i] && nr + 3 >= top && nr <= top + 29 &&
          nc + 3 >= left && nc <= left + 89) begin
        m_alive[i] = 1'b0;
        if (m_score < 255) m_score++;
        m_up = !m_up;
        hit = 1;
      end
    end
    if (hit) nr = m_row;
    if (m_left && nc < 40) begin nc = 40; m_left = 0; end
    else if (!m_left && nc + 3 > 589) begin nc = 586; m_left = 1; end
    missed = 0;
    if (m_up && nr < 30) begin nr = 30; m_up = 0; end
    else if (!m_up && m_row + 3 < 440 && nr + 3 >= 440 && nc + 3 >= pad && nc <= pad + 63) begin
      nr = 436; m_up = 1;
    end else if (nr > 476) missed = 1;
    if (missed) begin
      m_lives--;
      m_row = 420; m_col = 400;
      m_state = (m_lives == 0) ? 4 : 2;
    end else begin
      m_row = nr; m_col = nc;
    end
    if (m_alive == 12'd0) m_state = 3;
  endtask

  task automatic compareAll();
    checkOutput("ball_row", ball_row, m_row);
    checkOutput("ball_col", ball_col, m_col);
    checkOutput("brick_alive", brick_alive, m_alive);
    checkOutput("score", score, m_score);
    checkOutput("lives", lives, m_lives);
    checkOutput("state", state, m_state);
    checkOutput("busy_idle", busy, 0);
  endtask

  task automatic resetDut();
    reset = 1; start_pulse = 0; frame_tick = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    modelReset();
    compareAll();
  endtask

  // Pulse start/tick for one cycle, follow any update sequence to completion, then compare.
  task automatic applyStimulus(input bit start, input bit tick);
    bit frame;
    int n;
    frame = tick && (m_state == 1);
    start_pulse = start; frame_tick = tick;
    @(posedge clock);
    #1 start_pulse = 0; frame_tick = 0;
    if (start && m_state != 1) modelStart();
    else if (frame) modelFrame(int'(paddle_left));
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clock);
      #1;
    end
    checkOutput("busy_cycles", n, frame ? 13 : 0);
    compareAll();
  endtask

  initial begin
    int p;
    int r;
    paddle_left = 10'd40;
    resetDut();
    checkOutput("rst_alive", brick_alive, 12'hFFF);
    checkOutput("rst_lives", lives, 3);
    repeat (5) applyStimulus(0, 1);

    applyStimulus(1, 1);
    checkOutput("start_wins", state, 1);
    applyStimulus(0, 1);
    checkOutput("first_row", ball_row, 418);
    checkOutput("first_col", ball_col, 399);

    repeat (120) applyStimulus(0, 1);
    checkOutput("hit_alive", brick_alive, 12'hEFF);
    checkOutput("hit_score", score, 1);
    checkOutput("hit_row", ball_row, 180);
    checkOutput("hit_col", ball_col, 279);
    applyStimulus(0, 1);
    checkOutput("hit_down_row", ball_row, 182);

    repeat (148) applyStimulus(0, 1);
    checkOutput("miss_lives", lives, 2);
    checkOutput("miss_state", state, 2);
    checkOutput("miss_row", ball_row, 420);
    checkOutput("miss_col", ball_col, 400);
    applyStimulus(0, 1);
    checkOutput("miss_tick_state", state, 2);
    applyStimulus(1, 0);
    checkOutput("miss_restart", state, 1);
    checkOutput("miss_keep_alive", brick_alive, 12'hEFF);

    resetDut();
    paddle_left = 10'd120;
    applyStimulus(1, 0);
    repeat (121) applyStimulus(0, 1);
    repeat (129) applyStimulus(0, 1);
    checkOutput("pad_row", ball_row, 436);
    checkOutput("pad_col", ball_col, 150);
    checkOutput("pad_lives", lives, 3);
    applyStimulus(0, 1);
    checkOutput("pad_up_row", ball_row, 434);

    frame_tick = 1;
    @(posedge clock);
    #1 frame_tick = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    checkOutput("abort_busy_before", busy, 1);
    reset = 1;
    @(posedge clock);
    #1 reset = 0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_alive", brick_alive, 12'hFFF);
    checkOutput("abort_state", state, 0);
    modelReset();
    compareAll();

    resetDut();
    applyStimulus(1, 0);
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        p = m_col - int'($urandom_range(0, 60));
        if (p < 0) p = 0;
      end else begin
        p = int'($urandom_range(0, 600));
      end
      paddle_left = 10'(p);
      r = int'($urandom_range(0, 99));
      if (r < 5) applyStimulus(1, 1);
      else if (r < 10) applyStimulus(1, 0);
      else applyStimulus(0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/breakout_physics.md
# breakout_physics

Per-frame game engine for Breakout. It sits between the VGA timing generator and the pixel colour renderer. Once per frame, during vertical blanking, it moves the ball and resolves collisions against the walls, the paddle and a 12-brick grid. It publishes ball position, a brick-alive mask, score, lives and game state, which the renderer consumes as stable registers for the whole visible frame.

## Interface
Parameters:
- START_ROW, 420, ball serve row (top-left pixel of 4x4 ball)
- START_COL, 400, ball serve column
- LIVES, 3, lives per game (2-bit)
- PADDLE_W, 64, paddle width in pixels
- BRICK_LEFT, 40, column of brick grid left edge
- BRICK_TOP, 100, row of brick grid top edge
- BRICK_W, 90, brick width
- BRICK_H, 30, brick height
- ROW_PITCH, 50, row spacing between the two brick rows

Ports (reset: synchronous, active-high; clock: clock):
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse from the VGA timing block at row 480, col 0
- start_pulse  in  1  one-cycle press pulse from the start button conditioner
- paddle_left  in  10  leftmost column of the paddle; paddle occupies rows 440–459
- ball_row  out  9  ball top row
- ball_col  out  10  ball left column
- brick_alive  out  12  bit i = 1 means brick i is present
- score  out  8  bricks destroyed; saturates at 255
- lives  out  2  remaining lives
- state  out  3  IDLE=0, PLAY=1, MISS=2, WON=3, OVER=4
- busy  out  1  update sequence in progress

## Operation
- **Reset values:** state IDLE, ball (START_ROW, START_COL), brick_alive 12'hFFF, score 0, lives LIVES, busy 0, direction up+left.
- **Brick geometry:**
  - Brick i = r*6+c, with r in 0..1 and c in 0..5.
  - Columns: BRICK_LEFT+c*BRICK_W .. +BRICK_W-1.
  - Rows: BRICK_TOP+r*ROW_PITCH .. +BRICK_H-1.
- **Play area:** columns 40–589, top boundary row 30. All comparisons use 11-bit unsigned arithmetic, so nothing wraps.
- **start_pulse handling:**
  - In IDLE, WON or OVER: brick_alive=FFF, score=0, lives=LIVES, ball to start, direction up+left, state PLAY.
  - In MISS: ball to start, direction up+left, state PLAY; bricks, score and lives are kept.
  - In PLAY: ignored.
- **Update sequence (PLAY only, busy=0):**
  - The candidate position is row±2, col±1, according to the current direction.
  - SCAN: one cycle per brick, i = 0..11. The candidate 4x4 box is tested against brick i if it is alive.
    - On the first overlap: clear the bit, add 1 to score, flip vertical direction, keep the current row (candidate row discarded), and stop testing the remaining bricks. The scan still runs the full 12 cycles.
    - At most one brick is destroyed per frame.
  - COMMIT, in this priority order:
    - Left wall: moving left and col'<40 → col'=40, direction becomes right.
    - Right wall: moving right and col'+3>589 → col'=586, direction becomes left.
    - Top wall: moving up and row'<30 → row'=30, direction becomes down.
    - Paddle: moving down, row+3<440, row'+3≥440, col'+3≥paddle_left and col'≤paddle_left+PADDLE_W-1 → row'=436, direction becomes up.
    - Miss: row'>476 → lives decrements, ball goes to start. If lives reaches 0, state becomes OVER; otherwise MISS.
    - Otherwise the candidate position is written.
    - After the above: if brick_alive==0, state becomes WON.
  - Horizontal (wall) and vertical (brick/paddle) flips are independent; both apply in the same frame.
- frame_tick outside PLAY, or while busy=1, is ignored.
- start_pulse and frame_tick in the same cycle in IDLE: start wins and the tick is ignored.

## Timing
- Cycle 0: frame_tick is sampled.
- Cycles 1–12: SCAN bricks 0–11; busy=1. brick_alive and score update at the end of the hit cycle.
- Cycle 13: COMMIT; busy=1. ball_row, ball_col, lives and state are registered at the end of this cycle.
- Cycle 14: busy=0 and all outputs are final. The total of 14 cycles fits well within vertical blanking.
- start_pulse takes effect one cycle after it is sampled.
- Reset mid-sequence: the sequence aborts and all reset values appear on the next cycle.

## Test plan
- **Reset/idle:** reset, then 5 frame_ticks in IDLE → ball (420,400), brick_alive FFF, lives 3, score 0, state 0, busy stays 0.
- **First move:** start_pulse, then frame_tick → busy high for exactly 13 cycles; ball (418,399).
- **Brick hit:** paddle_left=40, 121 ticks after start → brick_alive 12'hEFF (brick 8 cleared), score 1, ball (180,279), direction down.
- **Miss:** continue with paddle_left=40 for 149 more ticks → lives 2, state MISS, ball (420,400). A frame_tick in MISS changes nothing; start_pulse returns state to PLAY.
- **Paddle bounce:** repeat the brick-hit run with paddle_left=120; after 129 more ticks → ball (436,150), direction up, lives 3.
- **Reset abort:** assert reset 5 cycles after a frame_tick in PLAY → next cycle busy 0, brick_alive FFF, state IDLE.
